// File: rtl/rref_matrix_loader.sv
// rtl/rref_matrix_loader.sv - assembles a row-major element stream into parallel NxN A/B buses for the RREF inverter
// Optional feature macro: RREF_LOADER_AUG_LOAD_EN (stream carries B after A instead of constant identity B).
module rref_matrix_loader #(
    parameter int DW = 32,
    parameter int N  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    input  logic              s_last,
    output logic [N*N*DW-1:0] mat_a,
    output logic [N*N*DW-1:0] mat_b,
    output logic              mat_valid,
    input  logic              mat_ack,
    output logic              err_len
);

    localparam int NN = N * N;
    localparam int IW = $clog2(2 * NN);
`ifdef RREF_LOADER_AUG_LOAD_EN
    localparam int T = 2 * NN;
`else
    localparam int T = NN;
`endif
    localparam logic [IW-1:0] LAST_IDX = IW'(T - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_next_idx;
    logic            r_ready;
    logic            r_valid;
    logic            r_err;
    logic            w_next_ready;
    logic            w_next_valid;
    logic            w_next_err;
    logic            w_xfer;
    logic            w_write;
    logic [DW-1:0]   r_a [NN];

    // r_ready is only ever set in FILL, so it alone qualifies a transfer
    assign w_xfer = s_valid && r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_ready <= w_next_ready;
            r_valid <= w_next_valid;
            r_err   <= w_next_err;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_err   = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            FILL: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        // a missing s_last still completes the matrix, but is flagged
                        w_next_state = HOLD;
                        w_next_idx   = '0;
                        w_write      = 1'b1;
                        w_next_err   = !s_last;
                    end else if (s_last) begin
                        w_next_idx = '0;
                        w_next_err = 1'b1;
                    end else begin
                        w_next_idx = r_idx + IW'(1);
                        w_write    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (mat_ack) begin
                    w_next_state = FILL;
                    w_next_idx   = '0;
                end
            end
            default: begin
                w_next_state = FILL;
                w_next_idx   = '0;
            end
        endcase
        w_next_ready = (w_next_state == FILL);
        w_next_valid = (w_next_state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NN; i++) r_a[i] <= '0;
        end else begin
            for (int i = 0; i < NN; i++)
                if (w_write && r_idx == IW'(i)) r_a[i] <= s_data;
        end
    end

`ifdef RREF_LOADER_AUG_LOAD_EN
    logic [DW-1:0] r_b [NN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NN; i++) r_b[i] <= '0;
        end else begin
            for (int i = 0; i < NN; i++)
                if (w_write && r_idx == IW'(NN + i)) r_b[i] <= s_data;
        end
    end
`endif

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign mat_a[(r*N+c)*DW +: DW] = r_a[r*N+c];
`ifdef RREF_LOADER_AUG_LOAD_EN
            assign mat_b[(r*N+c)*DW +: DW] = r_b[r*N+c];
`else
            assign mat_b[(r*N+c)*DW +: DW] = (r == c) ? DW'(1) : '0;
`endif
        end
    end

    assign s_ready   = r_ready;
    assign mat_valid = r_valid;
    assign err_len   = r_err;

endmodule

// File: tb/tb_rref_matrix_loader.sv
// tb/tb_rref_matrix_loader.sv - directed, table-driven bench for rref_matrix_loader
module tb_rref_matrix_loader;

    localparam int DW = 32;
    localparam int N  = 5;
    localparam int NN = N * N;
`ifdef RREF_LOADER_AUG_LOAD_EN
    localparam int TT = 2 * NN;
    localparam logic [DW-1:0] B_DIAG = 2;
    localparam logic [DW-1:0] B_RST  = 0;
`else
    localparam int TT = NN;
    localparam logic [DW-1:0] B_DIAG = 1;
    localparam logic [DW-1:0] B_RST  = 1;
`endif

    typedef struct {
        int          r;
        int          c;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              mat_ack = 1'b0;
    logic [DW-1:0]     s_data = '0;
    logic              s_ready;
    logic              mat_valid;
    logic              err_len;
    logic [N*N*DW-1:0] mat_a;
    logic [N*N*DW-1:0] mat_b;

    int checks = 0;
    int failures = 0;
    int xfers = 0;
    int errs = 0;
    int x0;
    int e0;
    logic [DW-1:0] t1 [NN];
    vec_t tbl [8];

    rref_matrix_loader #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .mat_a(mat_a), .mat_b(mat_b),
        .mat_valid(mat_valid), .mat_ack(mat_ack), .err_len(err_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_valid && s_ready) xfers++;
        if (err_len) errs++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(input int mode, input int k);
        if (k >= NN) return (((k - NN) / N) == ((k - NN) % N)) ? DW'(2) : DW'(0);
        if (mode == 0) return t1[k];
        return DW'(100 + k);
    endfunction

    function automatic logic [DW-1:0] a_at(input int k);
        return mat_a[k*DW +: DW];
    endfunction

    task automatic chk_mat_a(input string name, input int mode);
        int bad;
        bad = 0;
        for (int k = 0; k < NN; k++) if (a_at(k) !== elem(mode, k)) bad++;
        chk(name, bad, 0);
    endtask

    task automatic chk_mat_b(input string name, input logic [DW-1:0] diag);
        int bad;
        bad = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (mat_b[(r*N+c)*DW +: DW] !== ((r == c) ? diag : DW'(0))) bad++;
        chk(name, bad, 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last, input int gap);
        int w;
        w = 0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout s_ready actual=0 required=1");
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic load(input int mode, input int gap_max, input logic with_last);
        for (int k = 0; k < TT; k++)
            send(elem(mode, k), with_last && (k == TT - 1),
                 (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    endtask

    task automatic ack();
        mat_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mat_ack = 1'b0;
    endtask

    initial begin
        t1 = '{1, 1, 1, 1, 1, 5, 6, 5, 5, 5, 8, 8, 9, 8, 8,
               10, 10, 10, 11, 10, 13, 13, 13, 13, 14};
        tbl[0] = '{0, 0, 1, B_DIAG};
        tbl[1] = '{1, 1, 6, B_DIAG};
        tbl[2] = '{2, 2, 9, B_DIAG};
        tbl[3] = '{3, 3, 11, B_DIAG};
        tbl[4] = '{4, 4, 14, B_DIAG};
        tbl[5] = '{0, 1, 1, 0};
        tbl[6] = '{1, 0, 5, 0};
        tbl[7] = '{4, 3, 13, 0};

        // reset state
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mat_valid", mat_valid, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_mat_a_zero", (mat_a == '0), 1);
        chk_mat_b("rst_mat_b", B_RST);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_s_ready", s_ready, 1);

        // T1 basic load
        for (int k = 0; k < TT - 1; k++) send(elem(0, k), 1'b0, 0);
        chk("t1_valid_before_last", mat_valid, 0);
        send(elem(0, TT - 1), 1'b1, 0);
        chk("t1_valid_latency", mat_valid, 1);
        chk("t1_ready_low", s_ready, 0);
        @(negedge clk);
        chk("t1_no_err", errs, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_a%0d%0d", tbl[i].r, tbl[i].c), mat_a[(tbl[i].r*N+tbl[i].c)*DW +: DW], tbl[i].a);
            chk($sformatf("t1_b%0d%0d", tbl[i].r, tbl[i].c), mat_b[(tbl[i].r*N+tbl[i].c)*DW +: DW], tbl[i].b);
        end
        chk_mat_a("t1_mat_a", 0);
        chk_mat_b("t1_mat_b", B_DIAG);

        // T2 hold with producer pushing, then ack
        s_valid = 1'b1;
        s_data  = 55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_hold_ready", s_ready, 0);
            chk("t2_hold_valid", mat_valid, 1);
            chk_mat_a("t2_hold_mat_a", 0);
        end
        s_valid = 1'b0;
        ack();
        chk("t2_ack_valid", mat_valid, 0);
        chk("t2_ack_ready", s_ready, 1);
        load(1, 0, 1'b1);
        chk("t2_slot0", a_at(0), 100);
        chk_mat_a("t2_mat_a", 1);
        ack();

        // T3 gapped stream
        x0 = xfers;
        load(0, 3, 1'b1);
        chk("t3_xfers", xfers - x0, TT);
        chk("t3_valid", mat_valid, 1);
        chk_mat_a("t3_mat_a", 0);
        ack();

        // T4 early s_last on element 7
        e0 = errs;
        for (int k = 0; k < 6; k++) send(elem(0, k), 1'b0, 0);
        send(99, 1'b1, 0);
        @(negedge clk);
        chk("t4_err_pulse", errs - e0, 1);
        chk("t4_valid", mat_valid, 0);
        chk("t4_ready", s_ready, 1);
        load(0, 0, 1'b1);
        @(negedge clk);
        chk_mat_a("t4_mat_a", 0);
        chk("t4_err_once", errs - e0, 1);
        ack();

        // missing s_last on the final element
        e0 = errs;
        load(1, 0, 1'b0);
        @(negedge clk);
        chk("nolast_valid", mat_valid, 1);
        chk("nolast_err", errs - e0, 1);
        chk_mat_a("nolast_mat_a", 1);
        ack();

        // T5 reset mid-fill
        for (int k = 0; k < 12; k++) send(elem(0, k), 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", mat_valid, 0);
        chk("t5_ready", s_ready, 0);
        chk("t5_mat_a_zero", (mat_a == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(0, 0, 1'b1);
        chk("t5_reload_valid", mat_valid, 1);
        chk_mat_a("t5_mat_a", 0);
        chk_mat_b("t5_mat_b", B_DIAG);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
